system_button_irq_master: RTL and testbench

- Avalon-MM master that services an edge-capturing input PIO (5-bit button port, irq mask at offset 2, edge-capture at offset 3, write-to-clear).
- After reset it programs the PIO irq mask. On each irq it reads the edge-capture register, clears it, and presents the captured bits as a valid/ready event to downstream control logic (mode/set FSM).
- A holdoff counter after each event gives mechanical button debounce.

---
 rtl/system_button_irq_master.sv | 210 +++++++++++++++++++++
 tb/tb_system_button_irq_master.sv | 352 +++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/system_button_irq_master.sv
// Avalon-MM master that services an edge-capturing button PIO.
// It programs the PIO irq mask once after reset. On each irq it reads the
// edge-capture register and then clears it. Captured bits are offered
// downstream as a valid/ready event, followed by a debounce holdoff.
module system_button_irq_master #(
  parameter int unsigned       DATA_W         = 5,
  parameter logic [DATA_W-1:0] IRQ_MASK       = '1,
  parameter int unsigned       HOLDOFF_CYCLES = 1000,
  parameter int unsigned       CNT_W          = 16
) (
  input  logic              clk,
  input  logic              reset_n,
  input  logic              enable,
  input  logic              irq,
  output logic [1:0]        address,
  output logic              chipselect,
  output logic              write_n,
  output logic [31:0]       writedata,
  input  logic [31:0]       readdata,
  output logic              evt_valid,
  output logic [DATA_W-1:0] evt_data,
  input  logic              evt_ready,
  output logic [CNT_W-1:0]  evt_count,
  output logic              busy
);

  typedef enum logic [2:0] {
    S_INIT    = 3'd0,
    S_IDLE    = 3'd1,
    S_RD_ADDR = 3'd2,
    S_RD_DATA = 3'd3,
    S_CLR     = 3'd4,
    S_OUT     = 3'd5,
    S_HOLD    = 3'd6
  } state_e;

  // The holdoff counter only ever holds values up to HOLDOFF_CYCLES-1.
  localparam int unsigned HOLD_W    = (HOLDOFF_CYCLES > 1) ? $clog2(HOLDOFF_CYCLES) : 1;
  localparam int unsigned HOLD_LOAD = (HOLDOFF_CYCLES > 0) ? HOLDOFF_CYCLES - 1 : 0;

  localparam logic [1:0]  ADDR_NONE = 2'd0;
  localparam logic [1:0]  ADDR_MASK = 2'd2;
  localparam logic [1:0]  ADDR_EDGE = 2'd3;
  localparam logic [31:0] MASK_WORD = 32'(IRQ_MASK);

  state_e              state_q, state_d;
  logic                initPend_q, initPend_d;
  logic [HOLD_W-1:0]   hold_q, hold_d;
  logic [DATA_W-1:0]   cap_q, cap_d;
  logic [DATA_W-1:0]   evtData_q, evtData_d;
  logic                evtValid_q, evtValid_d;
  logic [CNT_W-1:0]    count_q, count_d;
  logic [1:0]          address_q, address_d;
  logic                cs_q, cs_d;
  logic                writeN_q, writeN_d;
  logic [31:0]         wdata_q, wdata_d;

  // Only the low DATA_W bits of the PIO read data carry button information.
  generate
    if (DATA_W < 32) begin : g_unusedReaddata
      logic unusedReaddata;
      assign unusedReaddata = ^readdata[31:DATA_W];
    end
  endgenerate

  // State, capture and counter registers. Reset parks the FSM in INIT with
  // the mask write still pending, so the write is issued after release.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q    <= S_INIT;
      initPend_q <= 1'b1;
      hold_q     <= '0;
      cap_q      <= '0;
      evtData_q  <= '0;
      count_q    <= '0;
    end else begin
      state_q    <= state_d;
      initPend_q <= initPend_d;
      hold_q     <= hold_d;
      cap_q      <= cap_d;
      evtData_q  <= evtData_d;
      count_q    <= count_d;
    end
  end

  // Bus and event-valid registers. They are loaded from the state being
  // entered, so each registered value lines up with the state it describes.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      address_q  <= ADDR_NONE;
      cs_q       <= 1'b0;
      writeN_q   <= 1'b1;
      wdata_q    <= '0;
      evtValid_q <= 1'b0;
    end else begin
      address_q  <= address_d;
      cs_q       <= cs_d;
      writeN_q   <= writeN_d;
      wdata_q    <= wdata_d;
      evtValid_q <= evtValid_d;
    end
  end

  // Next-state logic and the capture/holdoff/event datapath.
  // INIT spends its first cycle letting the bus registers pick up the mask
  // write. The following cycle is the one in which that write is visible.
  always_comb begin
    state_d    = state_q;
    initPend_d = initPend_q;
    hold_d     = hold_q;
    cap_d      = cap_q;
    evtData_d  = evtData_q;
    count_d    = count_q;
    case (state_q)
      S_INIT: begin
        if (initPend_q) begin
          initPend_d = 1'b0;
        end else begin
          state_d = S_IDLE;
        end
      end
      S_IDLE: begin
        if (irq && enable) begin
          state_d = S_RD_ADDR;
        end
      end
      S_RD_ADDR: begin
        state_d = S_RD_DATA;
      end
      S_RD_DATA: begin
        cap_d   = readdata[DATA_W-1:0] & IRQ_MASK;
        state_d = S_CLR;
      end
      S_CLR: begin
        if (cap_q != '0) begin
          evtData_d = cap_q;
          state_d   = S_OUT;
        end else begin
          state_d = S_IDLE;
        end
      end
      S_OUT: begin
        if (evt_ready) begin
          count_d = count_q + CNT_W'(1);
          if (HOLDOFF_CYCLES == 0) begin
            state_d = S_IDLE;
          end else begin
            hold_d  = HOLD_W'(HOLD_LOAD);
            state_d = S_HOLD;
          end
        end
      end
      S_HOLD: begin
        if (hold_q == '0) begin
          state_d = S_IDLE;
        end else begin
          hold_d = hold_q - HOLD_W'(1);
        end
      end
      default: begin
        state_d = S_INIT;
      end
    endcase
  end

  // Decode of the bus cycle and event-valid flag for the state being entered.
  always_comb begin
    address_d  = ADDR_NONE;
    cs_d       = 1'b0;
    writeN_d   = 1'b1;
    wdata_d    = '0;
    evtValid_d = 1'b0;
    case (state_d)
      S_INIT: begin
        cs_d      = 1'b1;
        writeN_d  = 1'b0;
        address_d = ADDR_MASK;
        wdata_d   = MASK_WORD;
      end
      S_RD_ADDR: begin
        cs_d      = 1'b1;
        address_d = ADDR_EDGE;
      end
      S_RD_DATA: begin
        address_d = ADDR_EDGE;
      end
      S_CLR: begin
        cs_d      = 1'b1;
        writeN_d  = 1'b0;
        address_d = ADDR_EDGE;
      end
      S_OUT: begin
        evtValid_d = 1'b1;
      end
      default: begin
        address_d = ADDR_NONE;
      end
    endcase
  end

  assign address    = address_q;
  assign chipselect = cs_q;
  assign write_n    = writeN_q;
  assign writedata  = wdata_q;
  assign evt_valid  = evtValid_q;
  assign evt_data   = evtData_q;
  assign evt_count  = count_q;
  assign busy       = (state_q != S_IDLE);

endmodule

// File: tb/tb_system_button_irq_master.sv
// Testbench for system_button_irq_master. It contains a behavioural
// edge-capturing PIO and a queue of expected events built from the
// button presses applied.
module tb_system_button_irq_master;

  localparam int DATA_W  = 5;
  localparam int HOLDOFF = 8;
  localparam int CNT_W   = 16;

  logic              clk = 1'b0;
  logic              reset_n = 1'b1;
  logic              enable = 1'b0;
  logic              irq;
  logic [1:0]        address;
  logic              chipselect;
  logic              write_n;
  logic [31:0]       writedata;
  logic [31:0]       pioReadData = '0;
  logic              evt_valid;
  logic [DATA_W-1:0] evt_data;
  logic              evt_ready = 1'b0;
  logic [CNT_W-1:0]  evt_count;
  logic              busy;

  logic [4:0] inPort   = 5'h1f;
  logic [4:0] prevPort = 5'h1f;
  logic [4:0] edgeCap  = '0;
  logic [4:0] irqMask  = '0;

  int cyc = 0;
  int totalReads = 0, totalWrites = 0;
  int lastReadCycle = -1, lastWriteCycle = -1;
  logic [1:0]  lastReadAddr = '0, lastWriteAddr = '0;
  logic [31:0] lastWriteData = '0;

  int testsRun = 0, testsFailed = 0;
  int modelCount = 0;
  logic [4:0] expQ[$];

  system_button_irq_master #(
    .DATA_W(DATA_W), .IRQ_MASK(5'b11111), .HOLDOFF_CYCLES(HOLDOFF), .CNT_W(CNT_W)
  ) dut (
    .clk(clk), .reset_n(reset_n), .enable(enable), .irq(irq),
    .address(address), .chipselect(chipselect), .write_n(write_n),
    .writedata(writedata), .readdata(pioReadData),
    .evt_valid(evt_valid), .evt_data(evt_data), .evt_ready(evt_ready),
    .evt_count(evt_count), .busy(busy)
  );

  always #5 clk = ~clk;

  // Cycle counter used to timestamp bus transactions and events.
  always @(posedge clk) cyc <= cyc + 1;

  // PIO model: falling-edge capture, irq mask at offset 2, write-to-clear capture at offset 3.
  // Read data is registered, and its upper bits carry junk.
  always @(posedge clk) begin
    prevPort <= inPort;
    if (chipselect && !write_n && address == 2'd2) irqMask <= writedata[4:0];
    edgeCap <= ((chipselect && !write_n && address == 2'd3) ? 5'b0 : edgeCap) | (prevPort & ~inPort);
    if (chipselect && write_n) begin
      case (address)
        2'd3:    pioReadData <= {27'($urandom), edgeCap};
        2'd2:    pioReadData <= {27'($urandom), irqMask};
        default: pioReadData <= {27'($urandom), inPort};
      endcase
    end
  end

  assign irq = |(edgeCap & irqMask);

  // Bus monitor that logs every chipselect cycle mid-period.
  always @(negedge clk) begin
    if (chipselect) begin
      if (write_n) begin
        totalReads++;
        lastReadCycle = cyc;
        lastReadAddr = address;
      end else begin
        totalWrites++;
        lastWriteCycle = cyc;
        lastWriteAddr = address;
        lastWriteData = writedata;
      end
    end
  end

  task automatic tick();
    @(negedge clk);
    #1;
  endtask

  // Press the buttons in mask for one cycle. irqCyc returns the cycle in which
  // the PIO capture register first holds the edge.
  task automatic applyStimulus(input logic [4:0] mask, output int irqCyc);
    inPort = inPort & ~mask;
    tick();
    irqCyc = cyc;
    inPort = inPort | mask;
  endtask

  task automatic waitEvt(input int maxCyc, output int seenCyc, output bit timedOut);
    timedOut = 1'b1;
    seenCyc = -1;
    for (int i = 0; i < maxCyc; i++) begin
      if (evt_valid) begin
        timedOut = 1'b0;
        seenCyc = cyc;
        break;
      end
      tick();
    end
  endtask

  task automatic test_reset();
    int rel, w0;
    enable = 1'b0;
    evt_ready = 1'b0;
    #1;
    reset_n = 1'b0;
    repeat (3) tick();
    testsRun++; if (address !== 2'd0) begin testsFailed++; $display("[TB] FAIL reset_address: got %0h, expected 0", address); end
    testsRun++; if (chipselect !== 1'b0) begin testsFailed++; $display("[TB] FAIL reset_cs: got %0b, expected 0", chipselect); end
    testsRun++; if (write_n !== 1'b1) begin testsFailed++; $display("[TB] FAIL reset_write_n: got %0b, expected 1", write_n); end
    testsRun++; if (writedata !== 32'h0) begin testsFailed++; $display("[TB] FAIL reset_writedata: got %0h, expected 0", writedata); end
    testsRun++; if (evt_valid !== 1'b0) begin testsFailed++; $display("[TB] FAIL reset_evt_valid: got %0b, expected 0", evt_valid); end
    testsRun++; if (evt_data !== 5'h0) begin testsFailed++; $display("[TB] FAIL reset_evt_data: got %0h, expected 0", evt_data); end
    testsRun++; if (evt_count !== 16'h0) begin testsFailed++; $display("[TB] FAIL reset_evt_count: got %0h, expected 0", evt_count); end
    testsRun++; if (busy !== 1'b1) begin testsFailed++; $display("[TB] FAIL reset_busy: got %0b, expected 1", busy); end
    w0 = totalWrites;
    rel = cyc;
    reset_n = 1'b1;
    repeat (10) tick();
    testsRun++; if (totalWrites - w0 != 1) begin testsFailed++; $display("[TB] FAIL init_write_count: got %0d, expected 1", totalWrites - w0); end
    testsRun++; if (lastWriteCycle - rel != 1) begin testsFailed++; $display("[TB] FAIL init_write_delay: got %0d, expected 1", lastWriteCycle - rel); end
    testsRun++; if (lastWriteAddr !== 2'd2) begin testsFailed++; $display("[TB] FAIL init_write_addr: got %0h, expected 2", lastWriteAddr); end
    testsRun++; if (lastWriteData !== 32'h1f) begin testsFailed++; $display("[TB] FAIL init_write_data: got %0h, expected 1f", lastWriteData); end
    testsRun++; if (totalReads != 0) begin testsFailed++; $display("[TB] FAIL init_no_reads: got %0d, expected 0", totalReads); end
    testsRun++; if (busy !== 1'b0) begin testsFailed++; $display("[TB] FAIL init_idle_busy: got %0b, expected 0", busy); end
    testsRun++; if (evt_valid !== 1'b0) begin testsFailed++; $display("[TB] FAIL init_evt_valid: got %0b, expected 0", evt_valid); end
    testsRun++; if (irqMask !== 5'h1f) begin testsFailed++; $display("[TB] FAIL init_pio_mask: got %0h, expected 1f", irqMask); end
    modelCount = 0;
  endtask

  task automatic test_single_edge(input int n);
    int irqCyc, seen, r0, w0, b;
    bit to;
    logic [4:0] m, exp;
    enable = 1'b1;
    evt_ready = 1'b1;
    for (int i = 0; i < n; i++) begin
      b = (i == 0) ? 2 : int'($urandom_range(0, 4));
      m = 5'(1 << b);
      expQ.push_back(m);
      r0 = totalReads;
      w0 = totalWrites;
      applyStimulus(m, irqCyc);
      waitEvt(20, seen, to);
      exp = expQ.pop_front();
      testsRun++; if (to) begin testsFailed++; $display("[TB] FAIL single_timeout: got no evt_valid, expected one within 20 cycles"); end
      testsRun++; if (seen - irqCyc != 4) begin testsFailed++; $display("[TB] FAIL single_latency: got %0d, expected 4", seen - irqCyc); end
      testsRun++; if (evt_data !== exp) begin testsFailed++; $display("[TB] FAIL single_data: got %0h, expected %0h", evt_data, exp); end
      testsRun++; if (totalReads - r0 != 1 || lastReadAddr !== 2'd3) begin testsFailed++; $display("[TB] FAIL single_read: got %0d reads last addr %0h, expected 1 at 3", totalReads - r0, lastReadAddr); end
      testsRun++; if (totalWrites - w0 != 1 || lastWriteAddr !== 2'd3 || lastWriteData !== 32'h0) begin testsFailed++; $display("[TB] FAIL single_clear: got %0d writes addr %0h data %0h, expected 1 at 3 data 0", totalWrites - w0, lastWriteAddr, lastWriteData); end
      modelCount++;
      tick();
      testsRun++; if (evt_valid !== 1'b0) begin testsFailed++; $display("[TB] FAIL single_valid_drop: got %0b, expected 0", evt_valid); end
      testsRun++; if (evt_count !== 16'(modelCount)) begin testsFailed++; $display("[TB] FAIL single_count: got %0d, expected %0d", evt_count, modelCount); end
      testsRun++; if (edgeCap !== 5'h0) begin testsFailed++; $display("[TB] FAIL single_pio_cleared: got %0h, expected 0", edgeCap); end
      repeat (HOLDOFF + 4) tick();
    end
  endtask

  task automatic test_holdoff(input int n);
    int irqCyc, seen, acc, r0, d;
    bit to;
    logic [4:0] m1, m2, exp;
    enable = 1'b1;
    evt_ready = 1'b1;
    for (int i = 0; i < n; i++) begin
      m1 = 5'(1 << $urandom_range(0, 4));
      expQ.push_back(m1);
      applyStimulus(m1, irqCyc);
      waitEvt(20, seen, to);
      exp = expQ.pop_front();
      testsRun++; if (to) begin testsFailed++; $display("[TB] FAIL holdoff_first_timeout: got no evt_valid, expected one within 20 cycles"); end
      testsRun++; if (evt_data !== exp) begin testsFailed++; $display("[TB] FAIL holdoff_first_data: got %0h, expected %0h", evt_data, exp); end
      modelCount++;
      acc = seen;
      r0 = totalReads;
      d = (i == 0) ? 3 : int'($urandom_range(1, 6));
      m2 = 5'($urandom_range(1, 31));
      expQ.push_back(m2);
      for (int c = 1; c <= HOLDOFF; c++) begin
        tick();
        if (c == d) inPort = inPort & ~m2;
        if (c == d + 1) inPort = inPort | m2;
      end
      testsRun++; if (busy !== 1'b1 || totalReads != r0) begin testsFailed++; $display("[TB] FAIL holdoff_ignored: got busy %0b reads %0d, expected busy 1 reads 0", busy, totalReads - r0); end
      testsRun++; if (irq !== 1'b1) begin testsFailed++; $display("[TB] FAIL holdoff_irq_pending: got %0b, expected 1", irq); end
      waitEvt(30, seen, to);
      exp = expQ.pop_front();
      testsRun++; if (to) begin testsFailed++; $display("[TB] FAIL holdoff_second_timeout: got no evt_valid, expected one within 30 cycles"); end
      testsRun++; if (lastReadCycle - acc != HOLDOFF + 2) begin testsFailed++; $display("[TB] FAIL holdoff_gap: got %0d, expected %0d", lastReadCycle - acc, HOLDOFF + 2); end
      testsRun++; if (evt_data !== exp) begin testsFailed++; $display("[TB] FAIL holdoff_second_data: got %0h, expected %0h", evt_data, exp); end
      modelCount++;
      tick();
      testsRun++; if (evt_count !== 16'(modelCount)) begin testsFailed++; $display("[TB] FAIL holdoff_count: got %0d, expected %0d", evt_count, modelCount); end
      repeat (HOLDOFF + 4) tick();
    end
  endtask

  task automatic test_backpressure();
    int irqCyc, seen, r0, w0, badValid, badData, badBus;
    bit to;
    logic [4:0] m2, exp;
    enable = 1'b1;
    evt_ready = 1'b0;
    expQ.push_back(5'b00001);
    applyStimulus(5'b00001, irqCyc);
    waitEvt(20, seen, to);
    exp = expQ.pop_front();
    testsRun++; if (to) begin testsFailed++; $display("[TB] FAIL bp_timeout: got no evt_valid, expected one within 20 cycles"); end
    testsRun++; if (evt_data !== exp) begin testsFailed++; $display("[TB] FAIL bp_data: got %0h, expected %0h", evt_data, exp); end
    m2 = 5'(1 << $urandom_range(0, 4));
    expQ.push_back(m2);
    r0 = totalReads;
    w0 = totalWrites;
    badValid = 0; badData = 0; badBus = 0;
    for (int k = 0; k < 20; k++) begin
      tick();
      if (k == 5) inPort = inPort & ~m2;
      if (k == 6) inPort = inPort | m2;
      if (evt_valid !== 1'b1) badValid++;
      if (evt_data !== 5'b00001) badData++;
      if (chipselect !== 1'b0) badBus++;
    end
    testsRun++; if (badValid != 0) begin testsFailed++; $display("[TB] FAIL bp_valid_stable: got %0d drops, expected 0", badValid); end
    testsRun++; if (badData != 0) begin testsFailed++; $display("[TB] FAIL bp_data_stable: got %0d changes, expected 0", badData); end
    testsRun++; if (badBus != 0 || totalReads != r0 || totalWrites != w0) begin testsFailed++; $display("[TB] FAIL bp_bus_quiet: got %0d active cycles, expected 0", badBus); end
    testsRun++; if (evt_count !== 16'(modelCount)) begin testsFailed++; $display("[TB] FAIL bp_count_before: got %0d, expected %0d", evt_count, modelCount); end
    evt_ready = 1'b1;
    modelCount++;
    tick();
    testsRun++; if (evt_valid !== 1'b0) begin testsFailed++; $display("[TB] FAIL bp_valid_drop: got %0b, expected 0", evt_valid); end
    testsRun++; if (evt_count !== 16'(modelCount)) begin testsFailed++; $display("[TB] FAIL bp_count_accept: got %0d, expected %0d", evt_count, modelCount); end
    repeat (4) tick();
    testsRun++; if (evt_count !== 16'(modelCount)) begin testsFailed++; $display("[TB] FAIL bp_count_once: got %0d, expected %0d", evt_count, modelCount); end
    waitEvt(40, seen, to);
    exp = expQ.pop_front();
    testsRun++; if (to) begin testsFailed++; $display("[TB] FAIL bp_pending_timeout: got no evt_valid, expected one within 40 cycles"); end
    testsRun++; if (evt_data !== exp) begin testsFailed++; $display("[TB] FAIL bp_pending_data: got %0h, expected %0h", evt_data, exp); end
    modelCount++;
    tick();
    testsRun++; if (evt_count !== 16'(modelCount)) begin testsFailed++; $display("[TB] FAIL bp_count_second: got %0d, expected %0d", evt_count, modelCount); end
    repeat (HOLDOFF + 4) tick();
  endtask

  task automatic test_enable();
    int irqCyc, seen, r0, w0, en;
    bit to;
    logic [4:0] m, exp;
    enable = 1'b0;
    evt_ready = 1'b1;
    m = 5'(1 << $urandom_range(0, 4));
    expQ.push_back(m);
    applyStimulus(m, irqCyc);
    r0 = totalReads;
    w0 = totalWrites;
    repeat (50) tick();
    testsRun++; if (totalReads != r0 || totalWrites != w0) begin testsFailed++; $display("[TB] FAIL enable_gated: got %0d transactions, expected 0", (totalReads - r0) + (totalWrites - w0)); end
    testsRun++; if (busy !== 1'b0 || irq !== 1'b1) begin testsFailed++; $display("[TB] FAIL enable_idle_irq: got busy %0b irq %0b, expected busy 0 irq 1", busy, irq); end
    enable = 1'b1;
    en = cyc;
    tick();
    testsRun++; if (lastReadCycle != en + 1 || totalReads != r0 + 1) begin testsFailed++; $display("[TB] FAIL enable_read_start: got cycle offset %0d, expected 1", lastReadCycle - en); end
    testsRun++; if (lastReadAddr !== 2'd3) begin testsFailed++; $display("[TB] FAIL enable_read_addr: got %0h, expected 3", lastReadAddr); end
    enable = 1'b0;
    waitEvt(20, seen, to);
    exp = expQ.pop_front();
    testsRun++; if (to) begin testsFailed++; $display("[TB] FAIL enable_midtxn_timeout: got no evt_valid, expected one within 20 cycles"); end
    testsRun++; if (evt_data !== exp) begin testsFailed++; $display("[TB] FAIL enable_midtxn_data: got %0h, expected %0h", evt_data, exp); end
    modelCount++;
    tick();
    testsRun++; if (evt_count !== 16'(modelCount)) begin testsFailed++; $display("[TB] FAIL enable_count: got %0d, expected %0d", evt_count, modelCount); end
    repeat (HOLDOFF + 4) tick();
    testsRun++; if (busy !== 1'b0) begin testsFailed++; $display("[TB] FAIL enable_back_idle: got %0b, expected 0", busy); end
    enable = 1'b1;
  endtask

  task automatic test_reset_mid();
    int irqCyc, seen, rel, w0;
    bit to;
    logic [4:0] m1, m2, exp;
    enable = 1'b1;
    evt_ready = 1'b0;
    m1 = 5'(1 << $urandom_range(0, 4));
    applyStimulus(m1, irqCyc);
    waitEvt(20, seen, to);
    testsRun++; if (to) begin testsFailed++; $display("[TB] FAIL rstmid_first_timeout: got no evt_valid, expected one within 20 cycles"); end
    m2 = 5'($urandom_range(1, 31));
    inPort = inPort & ~m2;
    tick();
    inPort = inPort | m2;
    tick();
    #1;
    reset_n = 1'b0;
    #1;
    modelCount = 0;
    testsRun++; if (evt_valid !== 1'b0) begin testsFailed++; $display("[TB] FAIL rstmid_valid: got %0b, expected 0", evt_valid); end
    testsRun++; if (evt_count !== 16'h0) begin testsFailed++; $display("[TB] FAIL rstmid_count: got %0d, expected 0", evt_count); end
    testsRun++; if (chipselect !== 1'b0 || busy !== 1'b1) begin testsFailed++; $display("[TB] FAIL rstmid_bus: got cs %0b busy %0b, expected cs 0 busy 1", chipselect, busy); end
    tick();
    expQ.push_back(m2);
    evt_ready = 1'b1;
    w0 = totalWrites;
    rel = cyc;
    reset_n = 1'b1;
    tick();
    tick();
    testsRun++; if (totalWrites != w0 + 1 || lastWriteCycle != rel + 1) begin testsFailed++; $display("[TB] FAIL rstmid_init_write: got %0d writes at offset %0d, expected 1 at 1", totalWrites - w0, lastWriteCycle - rel); end
    testsRun++; if (lastWriteAddr !== 2'd2 || lastWriteData !== 32'h1f) begin testsFailed++; $display("[TB] FAIL rstmid_init_value: got addr %0h data %0h, expected addr 2 data 1f", lastWriteAddr, lastWriteData); end
    waitEvt(20, seen, to);
    exp = expQ.pop_front();
    testsRun++; if (to) begin testsFailed++; $display("[TB] FAIL rstmid_pending_timeout: got no evt_valid, expected one within 20 cycles"); end
    testsRun++; if (evt_data !== exp) begin testsFailed++; $display("[TB] FAIL rstmid_pending_data: got %0h, expected %0h", evt_data, exp); end
    modelCount++;
    tick();
    testsRun++; if (evt_count !== 16'(modelCount)) begin testsFailed++; $display("[TB] FAIL rstmid_count_after: got %0d, expected %0d", evt_count, modelCount); end
    repeat (HOLDOFF + 4) tick();
  endtask

  // Scenario sequence followed by the summary line.
  initial begin
    test_reset();
    test_single_edge(4);
    test_holdoff(3);
    test_backpressure();
    test_enable();
    test_reset_mid();
    $display("[TB] %0d tests run, %0d failed", testsRun, testsFailed);
    $finish;
  end

  // Guard against a stalled run.
  initial begin
    #100000;
    $display("[TB] FAIL watchdog: got time limit reached, expected completion");
    $fatal(1, "[TB] watchdog expired");
  end

endmodule
